rv32_mod_muldiv: RTL and testbench

Multi-cycle RV32M multiply/divide unit. It is the sequential counterpart of the single-cycle integer ALU in the execute stage. The execute stage presents an M-extension operation with `start`, and the unit holds the pipeline via `stall` until the result is ready. It then pulses `done` for exactly one cycle, with `result` valid.

---
 rtl/rv32_mod_muldiv.sv | 174 +++++++++++++++++
 tb/tb_rv32_mod_muldiv.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mod_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32_mod_muldiv : multi-cycle RV32M multiply/divide unit (shift-add mul,   |
// | restoring div). Optional RV32_MULDIV_FAST_MUL_EN: single-cycle multiplies. |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module rv32_mod_muldiv (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  func,
  input  logic [31:0] read0_data,
  input  logic [31:0] read1_data,
  output logic [31:0] result,
  output logic        stall,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_func;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_opb;
  logic        r_neg;
  logic        r_neg_r;
  logic [5:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_done;

  logic        w_accept;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic [31:0] w_special_res;
  logic        w_fast;
  logic [31:0] w_fast_res;

  assign w_accept   = (r_state == S_IDLE) & start & ~kill;
  assign w_a_signed = func[2] ? ~func[0] : (func[1:0] != 2'b11);
  assign w_b_signed = func[2] ? ~func[0] : ~func[1];
  assign w_a_neg    = read0_data[31] & w_a_signed;
  assign w_b_neg    = read1_data[31] & w_b_signed;
  assign w_a_mag    = w_a_neg ? (~read0_data + 32'd1) : read0_data;
  assign w_b_mag    = w_b_neg ? (~read1_data + 32'd1) : read1_data;

  assign w_div_zero = func[2] & (read1_data == 32'd0);
  assign w_div_ovf  = func[2] & ~func[0] & (read0_data == 32'h8000_0000) &
                      (read1_data == 32'hFFFF_FFFF);
  // func[1] separates REM/REMU from DIV/DIVU
  assign w_special_res = w_div_zero ? (func[1] ? read0_data : 32'hFFFF_FFFF)
                                    : (func[1] ? 32'd0 : 32'h8000_0000);

`ifdef RV32_MULDIV_FAST_MUL_EN
  logic [63:0] w_fa;
  logic [63:0] w_fb;
  logic [63:0] w_fprod;

  // Low 64 bits of the 33x33 signed product, via sign-extended operands
  assign w_fa       = {{32{w_a_neg}}, read0_data};
  assign w_fb       = {{32{w_b_neg}}, read1_data};
  assign w_fprod    = w_fa * w_fb;
  assign w_fast     = w_div_zero | w_div_ovf | ~func[2];
  assign w_fast_res = func[2] ? w_special_res :
                      ((func[1:0] == 2'b00) ? w_fprod[31:0] : w_fprod[63:32]);
`else
  assign w_fast     = w_div_zero | w_div_ovf;
  assign w_fast_res = w_special_res;
`endif

  // One iteration step; r_hi/r_lo hold {accumulator, multiplier} or {remainder, dividend/quotient}
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_diff;
  logic [31:0] w_nxt_hi;
  logic [31:0] w_nxt_lo;

  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : 33'd0);
  assign w_div_shift = {r_hi, r_lo[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_diff  = w_div_shift[31:0] - r_opb;
  assign w_nxt_hi    = r_func[2] ? (w_div_ge ? w_div_diff : w_div_shift[31:0]) : w_mul_sum[32:1];
  assign w_nxt_lo    = r_func[2] ? {r_lo[30:0], w_div_ge} : {w_mul_sum[0], r_lo[31:1]};

  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;
  logic [31:0] w_iter_res;

  assign w_prod     = {w_nxt_hi, w_nxt_lo};
  assign w_prod_fix = r_neg   ? (~w_prod + 64'd1)   : w_prod;
  assign w_quo_fix  = r_neg   ? (~w_nxt_lo + 32'd1) : w_nxt_lo;
  assign w_rem_fix  = r_neg_r ? (~w_nxt_hi + 32'd1) : w_nxt_hi;
  assign w_iter_res = r_func[2] ? (r_func[1] ? w_rem_fix : w_quo_fix)
                                : ((r_func[1:0] == 2'b00) ? w_prod_fix[31:0] : w_prod_fix[63:32]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_func   <= 3'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_opb    <= 32'd0;
      r_neg    <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= 6'd0;
      r_result <= 32'd0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_func  <= func;
            r_hi    <= 32'd0;
            r_lo    <= w_a_mag;
            r_opb   <= w_b_mag;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= 6'd0;
            if (w_fast) begin
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (kill) begin
            r_state <= S_IDLE;
          end else begin
            r_hi  <= w_nxt_hi;
            r_lo  <= w_nxt_lo;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) begin
              r_result <= w_iter_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign stall  = rstn & (w_accept | ((r_state == S_BUSY) & ~kill));

endmodule
`default_nettype wire

// File: tb/tb_rv32_mod_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rv32_mod_muldiv : self-checking bench for rv32_mod_muldiv.              |
// | Revision: 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_rv32_mod_muldiv;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  func = 3'd0;
  logic [31:0] read0_data = 32'd0;
  logic [31:0] read1_data = 32'd0;
  logic [31:0] result;
  logic        stall;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = 32'd0;

  rv32_mod_muldiv dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .kill       (kill),
    .func       (func),
    .read0_data (read0_data),
    .read1_data (read1_data),
    .result     (result),
    .stall      (stall),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = 64'd0;
    q  = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sa / sb; p = q; return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa % sb; p = q; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 32'd0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef RV32_MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  // Entered at posedge+1 of an IDLE cycle; that cycle is the accept cycle (0).
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input string nm, input bit hold_next);
    logic [31:0] exp;
    int          lat, cyc;
    bit          stall_bad;
    exp = ref_model(f, a, b);
    lat = exp_latency(f, a, b);
    func = f; read0_data = a; read1_data = b; start = 1'b1; kill = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL %s accept_stall got %b want 1", nm, stall); end
    cyc = 0;
    stall_bad = 1'b0;
    do begin
      @(posedge clk); #1;
      cyc++;
      read0_data = $urandom;
      read1_data = $urandom;
      if (done !== 1'b1 && stall !== 1'b1) stall_bad = 1'b1;
    end while (done !== 1'b1 && cyc < 40);
    checks++;
    if (stall_bad) begin errors++; $display("FAIL %s busy_stall got 0 want 1", nm); end
    checks++;
    if (done !== 1'b1 || cyc != lat) begin
      errors++; $display("FAIL %s latency got %0d (done=%b) want %0d", nm, cyc, done, lat);
    end
    checks++;
    if (result !== exp) begin errors++; $display("FAIL %s result got %h want %h", nm, result, exp); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL %s done_stall got %b want 0", nm, stall); end
    last_res = exp;
    if (!hold_next) begin
      start = 1'b0;
      kill  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      kill = 1'b0;
      checks++;
      if (done !== 1'b0 || result !== exp) begin
        errors++; $display("FAIL %s after_done got done=%b result=%h want done=0 result=%h", nm, done, result, exp);
      end
    end
  endtask

  task automatic test_reset;
    start = 1'b1; func = 3'd4; read0_data = 32'd9; read1_data = 32'd2;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL reset got stall=%b done=%b result=%h want 0 0 0", stall, done, result);
    end
    @(posedge clk); #2;
    rstn = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL post_reset got stall=%b done=%b want 0 0", stall, done);
    end
  endtask

  task automatic test_mul;
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3", 1'b0);
    do_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, "mulh", 1'b0);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "mulhsu", 1'b0);
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "mulhu", 1'b0);
  endtask

  task automatic test_div;
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_-7/2", 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_-7/2", 1'b0);
    do_op(3'd5, 32'd100, 32'd7, "divu_100/7", 1'b0);
    do_op(3'd7, 32'd100, 32'd7, "remu_100/7", 1'b0);
  endtask

  task automatic test_special;
    do_op(3'd4, 32'd5, 32'd0, "div_by_zero", 1'b0);
    do_op(3'd7, 32'd5, 32'd0, "remu_by_zero", 1'b0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 1'b0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow", 1'b0);
  endtask

  task automatic test_kill;
    bit seen;
    func = 3'd5; read0_data = 32'd1000; read1_data = 32'd3; start = 1'b1; kill = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    kill = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL kill_stall got %b want 0", stall); end
    @(posedge clk); #1;
    kill = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || stall !== 1'b0 || result !== last_res) begin
      errors++; $display("FAIL kill_idle got done=%b stall=%b result=%h want 0 0 %h", done, stall, result, last_res);
    end
    seen = 1'b0;
    repeat (35) begin @(posedge clk); #1; if (done !== 1'b0) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL kill_no_done got done pulse want none"); end
    do_op(3'd5, 32'd1000, 32'd3, "divu_after_kill", 1'b0);
  endtask

  task automatic test_reset_midop;
    func = 3'd4; read0_data = 32'hFFFF_FF9C; read1_data = 32'd7; start = 1'b1; kill = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    checks++;
    if (result !== 32'd0 || done !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL midop_reset got result=%h done=%b stall=%b want 0 0 0", result, done, stall);
    end
    @(posedge clk); #2;
    rstn = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    last_res = 32'd0;
    checks++;
    if (done !== 1'b0 || result !== 32'd0) begin
      errors++; $display("FAIL midop_release got done=%b result=%h want 0 0", done, result);
    end
    do_op(3'd4, 32'hFFFF_FF9C, 32'd7, "div_after_reset", 1'b0);
  endtask

  task automatic test_back_to_back;
    do_op(3'd5, 32'd100, 32'd7, "b2b_first", 1'b1);
    func = 3'd7; read0_data = 32'd100; read1_data = 32'd7;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL b2b_idle got done=%b stall=%b want 0 1", done, stall);
    end
    do_op(3'd7, 32'd100, 32'd7, "b2b_second", 1'b0);
  endtask

  task automatic test_random;
    logic [2:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'($urandom_range(1, 5)) | {b[31], 31'd0};
        default: ;
      endcase
      do_op(f, a, b, "random", 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_kill();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
